// File: rtl/br_redirect_ctrl.sv
// Branch mispredict redirect controller: tracks the oldest outstanding mispredict, flushes on its commit, then redirects fetch.
// Optional statistics counters are enabled with `define BR_REDIRECT_STATS_EN.
module br_redirect_ctrl #(
  parameter int ROB_IDX_W    = 4,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_valid,
  input  logic                 br_en,
  input  logic [31:0]          br_pc_new,
  input  logic [ROB_IDX_W-1:0] br_rob_idx,
  input  logic [ROB_IDX_W-1:0] rob_head_idx,
  input  logic                 rob_commit,
  input  logic                 redirect_ready,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 stall_dispatch
`ifdef BR_REDIRECT_STATS_EN
  ,
  output logic [31:0]          stat_resolved,
  output logic [31:0]          stat_redirects
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_FLUSH, S_REDIRECT} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t               state, state_d;
  logic [31:0]          held_pc, held_pc_d, redirect_pc_d;
  logic [ROB_IDX_W-1:0] held_idx, held_idx_d;
  logic [ROB_IDX_W-1:0] new_age, held_age;
  logic [3:0]           cnt, cnt_d;
  logic                 mispredict, held_commits;

  // Ages are distances from the ROB head; the subtraction wraps with the ROB index.
  assign mispredict   = br_valid && br_en;
  assign new_age      = br_rob_idx - rob_head_idx;
  assign held_age     = held_idx - rob_head_idx;
  assign held_commits = rob_commit && (rob_head_idx == held_idx);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state;
    held_pc_d     = held_pc;
    held_idx_d    = held_idx;
    cnt_d         = cnt;
    redirect_pc_d = redirect_pc;
    case (state)
      S_IDLE: begin
        if (mispredict) begin
          held_pc_d  = br_pc_new;
          held_idx_d = br_rob_idx;
          state_d    = S_PENDING;
        end
      end
      S_PENDING: begin
        // A mispredict arriving alongside the held commit is younger and dies in the flush.
        if (held_commits) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_INIT;
        end else if (mispredict && (new_age < held_age)) begin
          held_pc_d  = br_pc_new;
          held_idx_d = br_rob_idx;
        end
      end
      S_FLUSH: begin
        if (cnt == 4'd1) begin
          state_d       = S_REDIRECT;
          redirect_pc_d = held_pc;
          cnt_d         = 4'd0;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      S_REDIRECT: begin
        if (redirect_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state       <= S_IDLE;
      held_pc     <= 32'd0;
      held_idx    <= '0;
      cnt         <= 4'd0;
      redirect_pc <= 32'd0;
    end else begin
      state       <= state_d;
      held_pc     <= held_pc_d;
      held_idx    <= held_idx_d;
      cnt         <= cnt_d;
      redirect_pc <= redirect_pc_d;
    end
  end

  assign flush          = (state == S_FLUSH);
  assign redirect_valid = (state == S_REDIRECT);
  assign stall_dispatch = (state == S_FLUSH) || (state == S_REDIRECT);

`ifdef BR_REDIRECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved  <= 32'd0;
      stat_redirects <= 32'd0;
    end else begin
      if (br_valid) stat_resolved <= stat_resolved + 32'd1;
      if ((state == S_PENDING) && held_commits) stat_redirects <= stat_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Directed bench for br_redirect_ctrl: instance a uses FLUSH_CYCLES=1, instance b uses FLUSH_CYCLES=3.
module tb_br_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid, br_en, rob_commit, redirect_ready;
  logic [31:0] br_pc_new;
  logic [3:0]  br_rob_idx, rob_head_idx;

  logic        a_flush, a_rv, a_stall;
  logic [31:0] a_rpc;
  logic        b_flush, b_rv, b_stall;
  logic [31:0] b_rpc;
`ifdef BR_REDIRECT_STATS_EN
  logic [31:0] a_stat_res, a_stat_red, b_stat_res, b_stat_red;
`endif

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  br_redirect_ctrl #(.ROB_IDX_W(4), .FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_en(br_en), .br_pc_new(br_pc_new),
    .br_rob_idx(br_rob_idx), .rob_head_idx(rob_head_idx), .rob_commit(rob_commit),
    .redirect_ready(redirect_ready), .flush(a_flush), .redirect_valid(a_rv),
    .redirect_pc(a_rpc), .stall_dispatch(a_stall)
`ifdef BR_REDIRECT_STATS_EN
    , .stat_resolved(a_stat_res), .stat_redirects(a_stat_red)
`endif
  );

  br_redirect_ctrl #(.ROB_IDX_W(4), .FLUSH_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_en(br_en), .br_pc_new(br_pc_new),
    .br_rob_idx(br_rob_idx), .rob_head_idx(rob_head_idx), .rob_commit(rob_commit),
    .redirect_ready(redirect_ready), .flush(b_flush), .redirect_valid(b_rv),
    .redirect_pc(b_rpc), .stall_dispatch(b_stall)
`ifdef BR_REDIRECT_STATS_EN
    , .stat_resolved(b_stat_res), .stat_redirects(b_stat_red)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=<empty scoreboard>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic mispredict(input logic [3:0] idx, input logic [31:0] pc);
    br_valid   = 1'b1;
    br_en      = 1'b1;
    br_rob_idx = idx;
    br_pc_new  = pc;
  endtask

  task automatic no_branch();
    br_valid   = 1'b0;
    br_en      = 1'b0;
    br_rob_idx = 4'd0;
    br_pc_new  = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    no_branch();
    rob_commit = 1'b0;
    redirect_ready = 1'b0;
    rob_head_idx = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check1("rst_flush", a_flush, 1'b0);
    check1("rst_rv", a_rv, 1'b0);
    check1("rst_stall", a_stall, 1'b0);
    check("rst_rpc", a_rpc, 32'd0);

    // Basic mispredict, commit, one-cycle flush, redirect
    mispredict(4'd3, 32'h6000_0040);
    tick();
    no_branch();
    check1("pend_flush", a_flush, 1'b0);
    check1("pend_stall", a_stall, 1'b0);
    rob_head_idx = 4'd3;
    rob_commit = 1'b1;
    exp_q.push_back(32'h6000_0040);
    tick();
    rob_commit = 1'b0;
    rob_head_idx = 4'd4;
    check1("s1_flush", a_flush, 1'b1);
    check1("s1_stall_flush", a_stall, 1'b1);
    check1("s1_rv_during_flush", a_rv, 1'b0);
    tick();
    check1("s1_flush_one_cycle", a_flush, 1'b0);
    check1("s1_rv", a_rv, 1'b1);
    check1("s1_stall_redir", a_stall, 1'b1);
    pop_check("s1_rpc", a_rpc);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check1("s1_idle_rv", a_rv, 1'b0);
    check1("s1_idle_stall", a_stall, 1'b0);

    // Not-taken branch is ignored
    br_valid = 1'b1;
    br_en = 1'b0;
    br_rob_idx = 4'd5;
    br_pc_new = 32'hDEAD_0000;
    rob_head_idx = 4'd4;
    tick();
    no_branch();
    rob_head_idx = 4'd5;
    rob_commit = 1'b1;
    tick();
    rob_commit = 1'b0;
    check1("nt_no_flush", a_flush, 1'b0);
    tick();
    check1("nt_no_flush2", a_flush, 1'b0);
    check1("nt_no_rv", a_rv, 1'b0);

    // Wrap-around age: head=14, held 1 (age 3), new 15 (age 1) replaces; 2 (age 4) dropped
    rob_head_idx = 4'd14;
    mispredict(4'd1, 32'h0000_0AAA);
    tick();
    mispredict(4'd15, 32'h0000_0100);
    tick();
    mispredict(4'd2, 32'h0000_0BAD);
    tick();
    no_branch();
    rob_head_idx = 4'd15;
    rob_commit = 1'b1;
    exp_q.push_back(32'h0000_0100);
    tick();
    rob_commit = 1'b0;
    check1("wrap_flush", a_flush, 1'b1);
    tick();
    check1("wrap_rv", a_rv, 1'b1);
    pop_check("wrap_rpc", a_rpc);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check1("wrap_idle", a_rv, 1'b0);

    // Held idx 5 commits together with new mispredict idx 6; FLUSH and REDIRECT ignore branches
    rob_head_idx = 4'd4;
    mispredict(4'd5, 32'h0000_0555);
    tick();
    rob_head_idx = 4'd5;
    rob_commit = 1'b1;
    mispredict(4'd6, 32'h0000_0666);
    exp_q.push_back(32'h0000_0555);
    tick();
    rob_commit = 1'b0;
    rob_head_idx = 4'd6;
    mispredict(4'd6, 32'h0000_0444);
    check1("same_flush", a_flush, 1'b1);
    tick();
    check1("same_rv", a_rv, 1'b1);
    pop_check("same_rpc", a_rpc);
    redirect_ready = 1'b1;
    mispredict(4'd7, 32'h0000_0777);
    tick();
    redirect_ready = 1'b0;
    no_branch();
    check1("same_idle", a_rv, 1'b0);
    rob_head_idx = 4'd7;
    rob_commit = 1'b1;
    tick();
    rob_commit = 1'b0;
    check1("redir_cycle_br_ignored", a_flush, 1'b0);
    tick();
    check1("flush_cycle_br_ignored", a_flush, 1'b0);

    // Reset during FLUSH aborts everything
    rob_head_idx = 4'd7;
    mispredict(4'd8, 32'h0000_0888);
    tick();
    no_branch();
    rob_head_idx = 4'd8;
    rob_commit = 1'b1;
    tick();
    rob_commit = 1'b0;
    check1("rstf_flush", a_flush, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check1("rstf_flush0", a_flush, 1'b0);
    check1("rstf_rv0", a_rv, 1'b0);
    check1("rstf_stall0", a_stall, 1'b0);
    check("rstf_rpc0", a_rpc, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check1("rstf_no_rv", a_rv, 1'b0);
      check1("rstf_no_flush", a_flush, 1'b0);
    end

    // FLUSH_CYCLES=3 with redirect_ready held low for 4 cycles (instance b)
    do_reset();
    mispredict(4'd2, 32'h1234_5678);
    tick();
    no_branch();
    rob_head_idx = 4'd2;
    rob_commit = 1'b1;
    exp_q.push_back(32'h1234_5678);
    tick();
    rob_commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check1("fc3_flush", b_flush, 1'b1);
      check1("fc3_stall_flush", b_stall, 1'b1);
      check1("fc3_rv_low", b_rv, 1'b0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      check1("fc3_flush_done", b_flush, 1'b0);
      check1("fc3_rv", b_rv, 1'b1);
      check1("fc3_stall_redir", b_stall, 1'b1);
      check("fc3_rpc_stable", b_rpc, 32'h1234_5678);
      tick();
    end
    pop_check("fc3_rpc", b_rpc);
    redirect_ready = 1'b1;
    tick();
    redirect_ready = 1'b0;
    check1("fc3_idle_rv", b_rv, 1'b0);
    check1("fc3_idle_stall", b_stall, 1'b0);

    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
